// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Groups the pipeline request/response signals and the data-memory bus
// of the load/store sequencer.
//   slave  : the sequencer (takes requests, drives the memory bus)
//   master : pipeline + memory side (issues requests, returns mem_dout)
// Request:  req, req_write, req_size, req_signed, req_addr, req_wdata, req_pc
// Response: busy, done, rdata
// Memory:   mem_pc, mem_we, mem_addr, mem_din, mem_be (out), mem_dout (in)
interface mem_access_unit_if;
  logic        req;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem_pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_be;
  logic [31:0] mem_dout;

  modport slave (
    input  req, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
    input  mem_dout,
    output busy, done, rdata, mem_pc, mem_we, mem_addr, mem_din, mem_be
  );

  modport master (
    output req, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
    output mem_dout,
    input  busy, done, rdata, mem_pc, mem_we, mem_addr, mem_din, mem_be
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer between the MEM stage and a word-organised,
// byte-enabled data memory. Aligned accesses take one memory cycle;
// misaligned halfword/word accesses are split into one-hot byte accesses.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   mau    slave modport of mem_access_unit_if (request, response, memory bus)
//
// state | meaning
// IDLE  | no request in flight
// ACC   | memory access cycle(s); busy=1
// DONE  | completion pulse; a new request may be accepted here
module mem_access_unit (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  mau
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  i_q, i_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        write_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] addr_hold_q, din_hold_q;

  logic        accept, aligned, last, in_acc, acc_live;
  logic [1:0]  last_idx, lane;
  logic [31:0] cur_addr, cur_din, raw, ext;
  logic [3:0]  cur_be;
  logic [7:0]  lane_byte;

  assign in_acc = (state_q == ACC);
  assign accept = mau.req && !in_acc;

  // size_q is normalised at accept, so 3 never appears here
  assign aligned  = (size_q == 2'd0) ||
                    (size_q == 2'd1 && !addr_q[0]) ||
                    (size_q == 2'd2 && addr_q[1:0] == 2'b00);
  assign last_idx = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;
  assign last     = aligned || (i_q == last_idx);
  assign cur_addr = aligned ? addr_q : addr_q + {30'b0, i_q};
  assign lane     = cur_addr[1:0];
  assign lane_byte = mau.mem_dout[{lane, 3'b000} +: 8];

  always_comb begin
    cur_be  = 4'b0001 << lane;
    cur_din = {4{wdata_q[{i_q, 3'b000} +: 8]}};
    if (aligned) begin
      cur_din = wdata_q << {lane, 3'b000};
      case (size_q)
        2'd0:    cur_be = 4'b0001 << lane;
        2'd1:    cur_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: cur_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    if (in_acc && !aligned) asm_d[{i_q, 3'b000} +: 8] = lane_byte;
    // asm_d already holds the byte captured this cycle
    raw = aligned ? (mau.mem_dout >> {lane, 3'b000}) : asm_d;
    case (size_q)
      2'd0:    ext = {{24{signed_q & raw[7]}}, raw[7:0]};
      2'd1:    ext = {{16{signed_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
    case (state_q)
      IDLE, DONE: begin
        if (mau.req) begin
          state_d = ACC;
          i_d     = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (last) begin
          state_d = DONE;
          if (!write_q) rdata_d = ext;
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q  <= mau.req_write;
        signed_q <= mau.req_signed;
        size_q   <= (mau.req_size == 2'd3) ? 2'd2 : mau.req_size;
        addr_q   <= mau.req_addr;
        wdata_q  <= mau.req_wdata;
        pc_q     <= mau.req_pc;
      end
      if (in_acc) begin
        addr_hold_q <= cur_addr;
        din_hold_q  <= cur_din;
      end
    end
  end

  // Strobes are cut during reset so an access interrupted by reset writes nothing more
  assign acc_live     = in_acc && !reset;
  assign mau.busy     = in_acc;
  assign mau.done     = (state_q == DONE);
  assign mau.rdata    = rdata_q;
  assign mau.mem_pc   = pc_q;
  assign mau.mem_we   = acc_live && write_q;
  assign mau.mem_be   = acc_live ? cur_be : 4'b0000;
  assign mau.mem_addr = in_acc ? cur_addr : addr_hold_q;
  assign mau.mem_din  = in_acc ? cur_din : din_hold_q;
endmodule
